// File: rtl/matrix_row_drain.sv
// matrix_row_drain: drains one PE row into a show-ahead result FIFO.
// MATRIX_DRAIN_CLEAR_EN: pulse pe_reset in CLEAR and while reset_n is low.
module matrix_row_drain #(
  parameter int N          = 4,
  parameter int W          = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         pe_read,
  output logic         pe_reset,
  output logic         pe_feed_zero,
  input  logic [W-1:0] pe_d_i,
  output logic [W-1:0] pe_r_d_o,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]   cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;

  logic full;
  logic push;
  logic pop;
  logic cap_last;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign cap_last = (cnt == CW'(N - 1));
  assign push     = pe_read;
  assign m_valid  = reset_n && (count != '0);
  assign pop      = m_valid && m_ready;
  assign m_data   = mem[rd_ptr];
  assign m_last   = m_valid && last_mem[rd_ptr];
  assign pe_r_d_o = '0;

`ifdef MATRIX_DRAIN_CLEAR_EN
  assign pe_reset = !reset_n || (state == CLEAR);
`else
  assign pe_reset = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = DRAIN;
      DRAIN:   if (push && cap_last) state_nx = CLEAR;
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read gating looks only at the registered count, never at m_ready.
  always_comb begin
    pe_read      = 1'b0;
    pe_feed_zero = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE: begin
        end
        DRAIN: begin
          pe_read      = !full;
          pe_feed_zero = 1'b1;
          busy         = 1'b1;
        end
        CLEAR: begin
          pe_feed_zero = 1'b1;
          busy         = 1'b1;
          done         = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= cap_last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem      <= '{default: '0};
      last_mem <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]      <= pe_d_i;
        last_mem[wr_ptr] <= cap_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_row_drain.sv
// Bench for matrix_row_drain: scoreboard of expected row words,
// directed timing/backpressure/reset checks, then random drains.
module tb_matrix_row_drain;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 2;

`ifdef MATRIX_DRAIN_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         m_ready = 1'b0;
  logic         pe_read;
  logic         pe_reset;
  logic         pe_feed_zero;
  logic [W-1:0] pe_d_i;
  logic [W-1:0] pe_r_d_o;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] row [N];
  int           ridx = 0;
  logic         start_go = 1'b0;
  int           checks = 0;
  int           fails = 0;
  logic         hold_v = 1'b0;
  logic [W-1:0] hold_d = '0;
  logic         hold_l = 1'b0;

  matrix_row_drain #(
    .N(N),
    .W(W),
    .FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .pe_read(pe_read),
    .pe_reset(pe_reset),
    .pe_feed_zero(pe_feed_zero),
    .pe_d_i(pe_d_i),
    .pe_r_d_o(pe_r_d_o),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Row model: each read shifts the next PE's result to the left port.
  assign pe_d_i = (ridx < N) ? row[ridx[1:0]] : '0;

  always @(posedge clk) begin
    if (start_go) ridx <= 0;
    else if (reset_n && pe_read) ridx <= ridx + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
        chk("hold_last", m_last, hold_l);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL extra_word: got %0h expected no output", m_data);
        end else begin
          e = q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
          chk("pe_r_d_o", pe_r_d_o, 0);
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  task automatic load_row(input bit fixed);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      row[i] = fixed ? W'(10 * (i + 1)) : W'($urandom);
      e.d = row[i];
      e.l = (i == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_go = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_go = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input bit junk);
    int n = 0;
    int nd = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (done) begin
        nd++;
        break;
      end
      @(posedge clk);
      #1;
      if (junk) start = ($urandom_range(0, 2) == 0);
      if (rnd) m_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    chk("done_seen", nd, 1);
    @(negedge clk);
    chk("busy_falls", busy, 0);
    if (done) nd++;
    repeat (2) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("done_once", nd, 1);
  endtask

  task automatic flush();
    int n = 0;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("flush_empty", q.size(), 0);
    @(negedge clk);
    chk("valid_low_after_flush", m_valid, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) row[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pe_read", pe_read, 0);
    chk("rst_feed_zero", pe_feed_zero, 0);
    chk("rst_pe_reset", pe_reset, CLR);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("m_data_after_reset", m_data, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pe_reset", pe_reset, 0);

    // Free-flowing drain of 10,20,30,40
    load_row(1'b1);
    m_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("pe_read_c%0d", c), pe_read, (c <= 4));
      chk($sformatf("done_c%0d", c), done, (c == 5));
      chk($sformatf("busy_c%0d", c), busy, (c <= 5));
      chk($sformatf("feed_zero_c%0d", c), pe_feed_zero, (c <= 5));
      chk($sformatf("pe_reset_c%0d", c), pe_reset, CLR && (c == 5));
      chk($sformatf("m_valid_c%0d", c), m_valid, (c >= 2 && c <= 5));
      if (c == 5) chk("last_with_40", m_last, 1);
      @(posedge clk);
      #1;
    end
    chk("basic_all_out", q.size(), 0);

    // Backpressure with a 2-entry FIFO
    load_row(1'b0);
    m_ready = 1'b0;
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("bp_pe_read_c%0d", c), pe_read, (c <= 2));
      chk($sformatf("bp_valid_c%0d", c), m_valid, (c >= 2));
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    wait_done(1'b0, 1'b0);
    flush();

    // Reset after the second capture discards buffered words
    load_row(1'b0);
    m_ready = 1'b0;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_read", pe_read, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    q.delete();
    @(negedge clk);
    chk("in_rst_read", pe_read, 0);
    chk("in_rst_busy", busy, 0);
    chk("in_rst_valid", m_valid, 0);
    chk("in_rst_feed", pe_feed_zero, 0);
    chk("in_rst_pe_reset", pe_reset, CLR);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_data", m_data, 0);

    // Random drains with random ready and stray starts while busy
    for (int t = 0; t < 15; t++) begin
      load_row(1'b0);
      pulse_start();
      wait_done(1'b1, 1'b1);
      if (t % 3 == 0) flush();
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
